// File: rtl/hex_scan_driver.sv
// Eight-digit multiplexed hex display scanner with a double-buffered value register.
// New writes wait in a pending buffer and only reach the display at a frame boundary.
module hex_scan_driver #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_wr_en,
  input  logic [31:0] i_wr_data,
  input  logic [3:0]  i_wr_be,
  input  logic        i_lz_en,
  output logic        o_wr_ready,
  output logic [31:0] o_value,
  output logic [3:0]  o_nibble,
  output logic [7:0]  o_digit_an,
  output logic        o_blank
);

  localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(SCAN_DIV - 1);

  logic [CW-1:0] count;
  logic [2:0]    idx, idx_nxt;
  logic [31:0]   disp_reg, pending, disp_nxt, pend_nxt;
  logic          pend_valid, lz_q, pv_nxt, lz_nxt;
  logic          tick, frame_end, wr_acc;

  function automatic logic [31:0] merge_bytes(input logic [31:0] base,
                                              input logic [31:0] data,
                                              input logic [3:0]  be);
    logic [31:0] r;
    r = base;
    for (int b = 0; b < 4; b++)
      if (be[b]) r[8*b +: 8] = data[8*b +: 8];
    return r;
  endfunction

  function automatic logic [3:0] digit_of(input logic [31:0] v, input logic [2:0] k);
    return v[4*k +: 4];
  endfunction

  function automatic logic blank_of(input logic [31:0] v, input logic [2:0] k,
                                    input logic lz);
    logic [31:0] upper;
    upper = v >> {k, 2'b00};
    return lz && (k != 3'd0) && (upper == 32'd0);
  endfunction

  // Next-state: a boundary clear of pend_valid wins over a write accepted in the same cycle.
  always_comb begin
    tick      = (count == CNT_MAX);
    frame_end = tick && (idx == 3'd7);
    wr_acc    = i_wr_en && !pend_valid;
    pend_nxt  = wr_acc ? merge_bytes(disp_reg, i_wr_data, i_wr_be) : pending;
    pv_nxt    = pend_valid | wr_acc;
    disp_nxt  = disp_reg;
    lz_nxt    = lz_q;
    if (frame_end) begin
      if (pend_valid) disp_nxt = pending;
      pv_nxt = 1'b0;
      lz_nxt = i_lz_en;
    end
    idx_nxt = tick ? idx + 3'd1 : idx;
  end

  // Outputs are registered from next-state so they always track the current state.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      count      <= '0;
      idx        <= 3'd0;
      disp_reg   <= 32'd0;
      pending    <= 32'd0;
      pend_valid <= 1'b0;
      lz_q       <= 1'b0;
      o_wr_ready <= 1'b1;
      o_value    <= 32'd0;
      o_nibble   <= 4'd0;
      o_digit_an <= 8'hFE;
      o_blank    <= 1'b0;
    end else begin
      count      <= tick ? '0 : count + CW'(1);
      idx        <= idx_nxt;
      disp_reg   <= disp_nxt;
      pending    <= pend_nxt;
      pend_valid <= pv_nxt;
      lz_q       <= lz_nxt;
      o_wr_ready <= ~pv_nxt;
      o_value    <= disp_nxt;
      o_nibble   <= digit_of(disp_nxt, idx_nxt);
      o_digit_an <= ~(8'h01 << idx_nxt);
      o_blank    <= blank_of(disp_nxt, idx_nxt, lz_nxt);
    end
  end

endmodule

// File: tb/tb_hex_scan_driver.sv
// Scoreboard bench for hex_scan_driver: a cycle model pushes expected outputs per
// driven cycle, popped and compared after each clock edge, plus directed constant checks.
module tb_hex_scan_driver;
  localparam int SCAN_DIV = 4;

  logic        clk = 1'b0, rst = 1'b1, wr_en = 1'b0, lz_en = 1'b0;
  logic [31:0] wr_data = 32'd0;
  logic [3:0]  wr_be = 4'd0;
  logic        wr_ready, blank;
  logic [31:0] value;
  logic [3:0]  nibble;
  logic [7:0]  an;

  always #5 clk = ~clk;

  hex_scan_driver #(.SCAN_DIV(SCAN_DIV)) dut (
    .i_clk(clk), .i_reset(rst), .i_wr_en(wr_en), .i_wr_data(wr_data),
    .i_wr_be(wr_be), .i_lz_en(lz_en), .o_wr_ready(wr_ready), .o_value(value),
    .o_nibble(nibble), .o_digit_an(an), .o_blank(blank)
  );

  typedef struct packed {
    logic [31:0] value;
    logic [3:0]  nibble;
    logic [7:0]  an;
    logic        blank;
    logic        ready;
  } exp_t;

  exp_t        sb[$];
  int          n_cmp = 0, n_bad = 0;
  logic [31:0] m_disp, m_pend;
  logic        m_pv, m_lz;
  int          m_cnt, m_idx;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  // Advance the model for the inputs now applied, push its prediction, clock, compare.
  task automatic step();
    exp_t        e;
    logic [31:0] od, op;
    logic        opv, tick, nz;
    if (rst) begin
      m_disp = 0; m_pend = 0; m_pv = 0; m_lz = 0; m_cnt = 0; m_idx = 0;
    end else begin
      od = m_disp; op = m_pend; opv = m_pv;
      tick = (m_cnt == SCAN_DIV - 1);
      if (wr_en && !opv) begin
        m_pend = od;
        for (int b = 0; b < 4; b++)
          if (wr_be[b]) m_pend[8*b +: 8] = wr_data[8*b +: 8];
        m_pv = 1'b1;
      end
      if (tick && m_idx == 7) begin
        if (opv) m_disp = op;
        m_pv = 1'b0;
        m_lz = lz_en;
      end
      m_cnt = tick ? 0 : m_cnt + 1;
      if (tick) m_idx = (m_idx + 1) % 8;
    end
    nz = 1'b0;
    for (int k = 0; k < 8; k++)
      if (k >= m_idx && m_disp[4*k +: 4] != 4'd0) nz = 1'b1;
    e.value  = m_disp;
    e.nibble = m_disp[4*m_idx +: 4];
    e.an     = ~(8'h01 << m_idx);
    e.blank  = m_lz && (m_idx > 0) && !nz;
    e.ready  = !m_pv;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("value", value, e.value);
    check("nibble", 32'(nibble), 32'(e.nibble));
    check("digit_an", 32'(an), 32'(e.an));
    check("blank", 32'(blank), 32'(e.blank));
    check("wr_ready", 32'(wr_ready), 32'(e.ready));
  endtask

  task automatic write(input logic [31:0] d, input logic [3:0] be);
    wr_data = d; wr_be = be; wr_en = 1'b1;
    step();
    wr_en = 1'b0;
  endtask

  task automatic to_boundary();
    int n = 0;
    do begin step(); n++; end while (!(m_cnt == 0 && m_idx == 0) && n < 100);
    check("boundary_reached", 32'(n < 100), 32'd1);
  endtask

  task automatic pre_boundary();
    int n = 0;
    while (!(m_cnt == SCAN_DIV - 1 && m_idx == 7) && n < 100) begin step(); n++; end
    check("pre_boundary_reached", 32'(n < 100), 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_value"}, value, 32'd0);
    check({tag, "_nibble"}, 32'(nibble), 32'd0);
    check({tag, "_an"}, 32'(an), 32'hFE);
    check({tag, "_blank"}, 32'(blank), 32'd0);
    check({tag, "_ready"}, 32'(wr_ready), 32'd1);
  endtask

  initial begin
    logic [3:0] exp_nib[8];
    logic [7:0] ea;
    exp_nib = '{4'hD, 4'hC, 4'hB, 4'hA, 4'h4, 4'h3, 4'h2, 4'h1};

    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    check_reset_outputs("rst");

    for (int j = 1; j <= 32; j++) begin
      step();
      ea = ~(8'h01 << ((j / 4) % 8));
      check("an_idle", 32'(an), 32'(ea));
      check("nib_idle", 32'(nibble), 32'd0);
    end

    lz_en = 1'b0;
    write(32'h1234_ABCD, 4'hF);
    check("ready_low_after_wr", 32'(wr_ready), 32'd0);
    check("value_held", value, 32'd0);
    to_boundary();
    check("value_1234abcd", value, 32'h1234_ABCD);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("frame_nib%0d", i), 32'(nibble), 32'(exp_nib[i]));
      repeat (4) step();
    end

    write(32'hFFFF_0000, 4'b0011);
    to_boundary();
    check("value_partial_be", value, 32'h1234_0000);

    lz_en = 1'b1;
    write(32'h0000_00A5, 4'hF);
    to_boundary();
    for (int i = 0; i < 8; i++) begin
      check($sformatf("blank_a5_idx%0d", i), 32'(blank), 32'(i >= 2));
      repeat (4) step();
    end
    write(32'h0, 4'hF);
    to_boundary();
    for (int i = 0; i < 8; i++) begin
      check($sformatf("blank_zero_idx%0d", i), 32'(blank), 32'(i >= 1));
      repeat (4) step();
    end

    lz_en = 1'b0;
    write(32'h1111_1111, 4'hF);
    wr_data = 32'h2222_2222; wr_be = 4'hF; wr_en = 1'b1;
    step();
    wr_en = 1'b0;
    check("ready_still_low", 32'(wr_ready), 32'd0);
    to_boundary();
    check("second_wr_ignored", value, 32'h1111_1111);

    write(32'hFFFF_FFFF, 4'h0);
    check("be0_accepted", 32'(wr_ready), 32'd0);
    to_boundary();
    check("be0_unchanged", value, 32'h1111_1111);

    pre_boundary();
    wr_data = 32'h3333_3333; wr_be = 4'hF; wr_en = 1'b1;
    step();
    check("bnd_wr_pend_cleared", 32'(wr_ready), 32'd1);
    check("bnd_value_kept", value, 32'h1111_1111);
    step();
    wr_en = 1'b0;
    check("retry_accepted", 32'(wr_ready), 32'd0);
    to_boundary();
    check("retry_displayed", value, 32'h3333_3333);

    write(32'h5555_5555, 4'hF);
    step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_reset_outputs("midrst");
    to_boundary();
    check("pending_discarded1", value, 32'd0);
    to_boundary();
    check("pending_discarded2", value, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
